usb_ep_in_trans_seq: RTL

Transaction sequencer for one device-IN endpoint: on an IN token it reads the endpoint's committed transaction FIFO (pop side) and streams a DATA0/DATA1 packet to the packet transmitter, or answers NAK if nothing is committed. It then waits for the host handshake and commits (ACK) or rolls back (timeout/invalid) the FIFO pop transaction. It also owns the endpoint's IN data-toggle bit. It sits in the protocol engine between the token decoder, the endpoint FIFO and the transmitter.

---
 rtl/usb_ep_in_trans_seq.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/usb_ep_in_trans_seq.sv
// usb_ep_in_trans_seq: device-IN endpoint transaction sequencer.
// Streams committed FIFO bytes as DATA0/1 or answers NAK, then commits/rolls back.
module usb_ep_in_trans_seq #(
  parameter int unsigned MAX_PACKET_SIZE = 64,
  parameter int unsigned HS_TIMEOUT      = 18,
  parameter bit          ISOCHRONOUS     = 1'b0
) (
  input  logic       clk12_i,
  input  logic       rst_i,
  input  logic       inToken_i,
  input  logic       resetDataToggle_i,
  input  logic       epDataAvailable_i,
  input  logic [7:0] epData_i,
  input  logic       epIsLast_i,
  output logic       epPopData_o,
  output logic       epPopTransDone_o,
  output logic       epPopTransSuccess_o,
  output logic       txReq_o,
  input  logic       txAck_i,
  output logic       txIsHandshake_o,
  output logic [3:0] txPid_o,
  output logic       txDataValid_o,
  output logic [7:0] txData_o,
  output logic       txLast_o,
  input  logic       txDataReady_i,
  input  logic       txDone_i,
  input  logic       rxAck_i,
  input  logic       rxInvalid_i,
  output logic       busy_o,
  output logic       dataToggle_o
);

  localparam logic [3:0] PID_DATA0 = 4'b0011;
  localparam logic [3:0] PID_DATA1 = 4'b1011;
  localparam logic [3:0] PID_NAK   = 4'b1010;
  localparam logic [9:0] CNT_LAST  = 10'(MAX_PACKET_SIZE - 1);
  localparam logic [15:0] TMO_LAST = 16'(HS_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ_NAK,
    S_REQ_DATA,
    S_SEND,
    S_WAIT_TX,
    S_WAIT_HS,
    S_FINISH
  } state_t;

  state_t      state_q, state_d;
  logic        isNak_q, isNak_d;
  logic        succ_q, succ_d;
  logic        toggle_q, toggle_d;
  logic [9:0]  cnt_q, cnt_d;
  logic [15:0] tmo_q, tmo_d;
  logic        flip;

  always_ff @(posedge clk12_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      isNak_q  <= 1'b0;
      succ_q   <= 1'b0;
      toggle_q <= 1'b0;
      cnt_q    <= '0;
      tmo_q    <= '0;
    end else begin
      state_q  <= state_d;
      isNak_q  <= isNak_d;
      succ_q   <= succ_d;
      toggle_q <= toggle_d;
      cnt_q    <= cnt_d;
      tmo_q    <= tmo_d;
    end
  end

  always_comb begin
    state_d             = state_q;
    isNak_d             = isNak_q;
    succ_d              = succ_q;
    cnt_d               = cnt_q;
    tmo_d               = tmo_q;
    flip                = 1'b0;
    epPopData_o         = 1'b0;
    epPopTransDone_o    = 1'b0;
    epPopTransSuccess_o = 1'b0;
    txReq_o             = 1'b0;
    txIsHandshake_o     = 1'b0;
    txPid_o             = 4'b0000;
    txDataValid_o       = 1'b0;
    txData_o            = 8'h00;
    txLast_o            = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (inToken_i) begin
          if (epDataAvailable_i || ISOCHRONOUS) begin
            state_d = S_REQ_DATA;
            isNak_d = 1'b0;
          end else begin
            state_d = S_REQ_NAK;
            isNak_d = 1'b1;
          end
        end
      end
      S_REQ_NAK: begin
        txReq_o         = 1'b1;
        txIsHandshake_o = 1'b1;
        txPid_o         = PID_NAK;
        if (txAck_i) state_d = S_WAIT_TX;
      end
      S_REQ_DATA: begin
        txReq_o = 1'b1;
        txPid_o = (toggle_q && !ISOCHRONOUS) ? PID_DATA1 : PID_DATA0;
        cnt_d   = '0;
        if (txAck_i) begin
          state_d = epDataAvailable_i ? S_SEND : S_WAIT_TX;
        end
      end
      S_SEND: begin
        txDataValid_o = epDataAvailable_i;
        txData_o      = epData_i;
        txLast_o      = epIsLast_i | (cnt_q == CNT_LAST);
        epPopData_o   = txDataValid_o & txDataReady_i;
        if (epPopData_o) begin
          cnt_d = cnt_q + 10'd1;
          if (txLast_o) state_d = S_WAIT_TX;
        end
      end
      S_WAIT_TX: begin
        if (txDone_i) begin
          if (isNak_q) begin
            state_d = S_IDLE;
          end else if (ISOCHRONOUS) begin
            state_d = S_FINISH;
            succ_d  = 1'b1;
          end else begin
            state_d = S_WAIT_HS;
            tmo_d   = '0;
          end
        end
      end
      S_WAIT_HS: begin
        tmo_d = tmo_q + 16'd1;
        // ACK beats a same-cycle invalid packet or timeout
        if (rxAck_i) begin
          state_d = S_FINISH;
          succ_d  = 1'b1;
          flip    = !ISOCHRONOUS;
        end else if (rxInvalid_i || (tmo_q == TMO_LAST)) begin
          state_d = S_FINISH;
          succ_d  = 1'b0;
        end
      end
      S_FINISH: begin
        epPopTransDone_o    = 1'b1;
        epPopTransSuccess_o = succ_q;
        state_d             = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    toggle_d = toggle_q ^ flip;
    if (resetDataToggle_i || ISOCHRONOUS) toggle_d = 1'b0;
  end

  assign busy_o       = (state_q != S_IDLE);
  assign dataToggle_o = toggle_q;

endmodule
